// File: rtl/mult_arbiter_if.sv
// Bus between mult_arbiter, its two requesters and the external shift-add datapath.
// The slave side is the arbiter/controller; the master side drives requests and datapath state.
interface mult_arbiter_if;
  logic [1:0]  Req;
  logic [7:0]  Mcand0;
  logic [7:0]  Mcand1;
  logic [7:0]  Mplier0;
  logic [7:0]  Mplier1;
  logic        M;
  logic [7:0]  Aval;
  logic [7:0]  Bval;
  logic [1:0]  Gnt;
  logic [7:0]  S;
  logic        ClearAX;
  logic        LoadB;
  logic        LoadAX;
  logic        Shift;
  logic        Sub;
  logic        Busy;
  logic        Done;
  logic [15:0] Product;
  logic        ResultId;

  modport slave (
    input  Req, Mcand0, Mcand1, Mplier0, Mplier1, M, Aval, Bval,
    output Gnt, S, ClearAX, LoadB, LoadAX, Shift, Sub, Busy, Done, Product, ResultId
  );

  modport master (
    output Req, Mcand0, Mcand1, Mplier0, Mplier1, M, Aval, Bval,
    input  Gnt, S, ClearAX, LoadB, LoadAX, Shift, Sub, Busy, Done, Product, ResultId
  );
endinterface

// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a signed 8x8 shift-add multiplier.
// Sequences the external A/B/X datapath and returns a 16-bit product tagged with its owner.
module mult_arbiter (
  input  logic          Clk,
  input  logic          Reset,
  mult_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ADD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic        ptr;
  logic [7:0]  mcand_q;
  logic [7:0]  mplier_q;
  logic        id_q;
  logic [15:0] product_q;
  logic        result_id_q;

  logic        winner;
  logic [1:0]  gnt;
  logic [7:0]  s_bus;
  logic        clear_ax;
  logic        load_b;
  logic        load_ax;
  logic        shift;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        result_id;

  // A lone requester always wins; on contention the pointer decides.
  always_comb begin
    winner = ptr;
    if (bus.Req == 2'b01) winner = 1'b0;
    else if (bus.Req == 2'b10) winner = 1'b1;
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt         <= 3'd0;
      ptr         <= 1'b0;
      mcand_q     <= 8'h00;
      mplier_q    <= 8'h00;
      id_q        <= 1'b0;
      product_q   <= 16'h0000;
      result_id_q <= 1'b0;
    end else begin
      if (gnt != 2'b00) begin
        mcand_q  <= winner ? bus.Mcand1  : bus.Mcand0;
        mplier_q <= winner ? bus.Mplier1 : bus.Mplier0;
        id_q     <= winner;
        ptr      <= ~winner;
        cnt      <= 3'd0;
      end
      if (state == ST_SHIFT && cnt != 3'd7) cnt <= cnt + 3'd1;
      if (state == ST_DONE) begin
        product_q   <= {bus.Aval, bus.Bval};
        result_id_q <= id_q;
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no latch is inferred.
    state_nxt = state;
    gnt       = 2'b00;
    s_bus     = 8'h00;
    clear_ax  = 1'b0;
    load_b    = 1'b0;
    load_ax   = 1'b0;
    shift     = 1'b0;
    sub       = 1'b0;
    done      = 1'b0;
    busy      = (state != ST_IDLE);
    product   = product_q;
    result_id = result_id_q;

    unique case (state)
      ST_IDLE: begin
        if (bus.Req != 2'b00) begin
          gnt[winner] = 1'b1;
          state_nxt   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        clear_ax  = 1'b1;
        load_b    = 1'b1;
        s_bus     = mplier_q;
        state_nxt = ST_ADD;
      end
      ST_ADD: begin
        // The final partial product carries the multiplier sign, so it is subtracted.
        s_bus     = mcand_q;
        load_ax   = bus.M;
        sub       = bus.M && (cnt == 3'd7);
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift     = 1'b1;
        state_nxt = (cnt == 3'd7) ? ST_DONE : ST_ADD;
      end
      ST_DONE: begin
        // Present the finished product in the Done cycle itself; the register holds it afterwards.
        done      = 1'b1;
        product   = {bus.Aval, bus.Bval};
        result_id = id_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // NOTE: reset is synchronous, so state is still stale during the reset cycle; force outputs low here.
    if (Reset) begin
      state_nxt = ST_IDLE;
      gnt       = 2'b00;
      s_bus     = 8'h00;
      clear_ax  = 1'b0;
      load_b    = 1'b0;
      load_ax   = 1'b0;
      shift     = 1'b0;
      sub       = 1'b0;
      done      = 1'b0;
      busy      = 1'b0;
      product   = product_q;
      result_id = result_id_q;
    end
  end

  assign bus.Gnt      = gnt;
  assign bus.S        = s_bus;
  assign bus.ClearAX  = clear_ax;
  assign bus.LoadB    = load_b;
  assign bus.LoadAX   = load_ax;
  assign bus.Shift    = shift;
  assign bus.Sub      = sub;
  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.Product  = product;
  assign bus.ResultId = result_id;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: behavioural A/B/X datapath, scoreboard of expected
// products pushed when requests are driven and popped on each Done pulse.
module tb_mult_arbiter;

  logic Clk = 1'b0;
  logic Reset;

  mult_arbiter_if bus ();

  mult_arbiter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        id;
    logic [15:0] prod;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // External datapath: X:A:B with sign-extending add/subtract and arithmetic right shift.
  logic [7:0] dp_a;
  logic [7:0] dp_b;
  logic       dp_x;
  logic [8:0] dp_sum;

  always_comb
    dp_sum = bus.Sub ? ({dp_a[7], dp_a} - {bus.S[7], bus.S})
                     : ({dp_a[7], dp_a} + {bus.S[7], bus.S});

  always @(posedge Clk) begin
    if (Reset) begin
      dp_a <= 8'h00;
      dp_b <= 8'h00;
      dp_x <= 1'b0;
    end else begin
      if (bus.ClearAX) begin
        dp_a <= 8'h00;
        dp_x <= 1'b0;
      end
      if (bus.LoadB) dp_b <= bus.S;
      if (bus.LoadAX) begin
        dp_a <= dp_sum[7:0];
        dp_x <= dp_sum[8];
      end
      if (bus.Shift) begin
        dp_a <= {dp_x, dp_a[7:1]};
        dp_b <= {dp_a[0], dp_b[7:1]};
      end
    end
  end

  assign bus.M    = dp_b[0];
  assign bus.Aval = dp_a;
  assign bus.Bval = dp_b;

  // Per-cycle control legality.
  logic ctrl_ok;
  assign ctrl_ok = (bus.Gnt != 2'b11)
                && $onehot0({bus.LoadB, bus.LoadAX, bus.Shift})
                && !(bus.ClearAX && !bus.LoadB)
                && !((bus.Gnt != 2'b00) && bus.Busy)
                && !(Reset && ({bus.Gnt, bus.Done, bus.Busy, bus.S, bus.ClearAX,
                                bus.LoadB, bus.LoadAX, bus.Shift, bus.Sub} != '0));

  function automatic logic [15:0] ref_mul(input logic [7:0] mc, input logic [7:0] mp);
    logic signed [7:0] a;
    logic signed [7:0] b;
    int                p;
    a = mc;
    b = mp;
    p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  // Mid-cycle control check, then advance to just after the next rising edge.
  task automatic step();
    @(negedge Clk);
    n_checks++;
    if (!ctrl_ok) begin
      n_fail++;
      $display("FAIL ctrl_onehot @%0d: gnt=%b ldb=%b ldax=%b sh=%b clr=%b busy=%b rst=%b required legal/zero controls",
               cyc, bus.Gnt, bus.LoadB, bus.LoadAX, bus.Shift, bus.ClearAX, bus.Busy, Reset);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic load_operands(input int r, input logic [7:0] mc, input logic [7:0] mp);
    if (r == 0) begin
      bus.Mcand0  = mc;
      bus.Mplier0 = mp;
    end else begin
      bus.Mcand1  = mc;
      bus.Mplier1 = mp;
    end
  endtask

  task automatic push_exp(input int id, input logic [15:0] prod);
    exp_t e;
    e.id   = 1'(id);
    e.prod = prod;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input int budget, output logic [1:0] g);
    int n = 0;
    while (bus.Gnt === 2'b00 && n < budget) begin
      step();
      n++;
    end
    g = bus.Gnt;
  endtask

  // Steps until Done, then pops the scoreboard and compares.
  task automatic await_done(input int budget, output int steps);
    exp_t e;
    steps = 0;
    do begin
      step();
      steps++;
    end while (bus.Done !== 1'b1 && steps < budget);
    n_checks++;
    if (bus.Done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: no Done within %0d cycles", budget);
    end else if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL done_unexpected: Done with empty scoreboard, product=%h", bus.Product);
    end else begin
      e = sb.pop_front();
      if (bus.Product !== e.prod || bus.ResultId !== e.id) begin
        n_fail++;
        $display("FAIL product: got %h id %b, expected %h id %b", bus.Product, bus.ResultId, e.prod, e.id);
      end
    end
  endtask

  task automatic do_op(input int id, input logic [7:0] mc, input logic [7:0] mp, input logic [15:0] exp);
    logic [1:0] g;
    int         lat;
    load_operands(id, mc, mp);
    push_exp(id, exp);
    bus.Req = 2'(1 << id);
    #1;
    wait_gnt(40, g);
    n_checks++;
    if (g !== 2'(1 << id)) begin
      n_fail++;
      $display("FAIL op_gnt: got %b expected %b", g, 2'(1 << id));
    end
    step();
    bus.Req = 2'b00;
    load_operands(id, ~mc, ~mp);
    #1;
    n_checks++;
    if (!(bus.ClearAX && bus.LoadB) || bus.S !== mp) begin
      n_fail++;
      $display("FAIL load_state: clr=%b ldb=%b S=%h, expected 1 1 %h", bus.ClearAX, bus.LoadB, bus.S, mp);
    end
    step();
    n_checks++;
    if (bus.S !== mc || bus.Sub !== 1'b0) begin
      n_fail++;
      $display("FAIL add_state: S=%h sub=%b, expected %h 0", bus.S, bus.Sub, mc);
    end
    await_done(40, lat);
    n_checks++;
    if (lat + 2 != 18) begin
      n_fail++;
      $display("FAIL latency: Done at cycle %0d, expected 18", lat + 2);
    end
    step();
    n_checks++;
    if (bus.Product !== exp || bus.ResultId !== 1'(id) || bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: product=%h id=%b busy=%b, expected %h %0d 0", bus.Product, bus.ResultId, bus.Busy, exp, id);
    end
  endtask

  task automatic test_reset();
    Reset   = 1'b1;
    bus.Req = 2'b11;
    load_operands(0, 8'h33, 8'h44);
    load_operands(1, 8'h55, 8'h66);
    repeat (3) step();
    n_checks++;
    if (bus.Gnt !== 2'b00 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.S !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b busy=%b done=%b S=%h, expected all zero", bus.Gnt, bus.Busy, bus.Done, bus.S);
    end
    bus.Req = 2'b00;
    Reset   = 1'b0;
    step();
    n_checks++;
    if (bus.Product !== 16'h0000 || bus.ResultId !== 1'b0 || bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: product=%h id=%b busy=%b, expected 0000 0 0", bus.Product, bus.ResultId, bus.Busy);
    end
  endtask

  task automatic test_basic();
    do_op(0, 8'h07, 8'h03, 16'h0015);
  endtask

  task automatic test_signed();
    do_op(1, 8'hFF, 8'h02, 16'hFFFE);
    do_op(1, 8'h80, 8'h80, 16'h4000);
    do_op(0, 8'h7F, 8'h80, 16'hC080);
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    int         lat;
    load_operands(0, 8'h12, 8'hF6);
    load_operands(1, 8'h9C, 8'h3B);
    Reset   = 1'b1;
    bus.Req = 2'b11;
    step();
    step();
    Reset = 1'b0;
    push_exp(0, ref_mul(8'h12, 8'hF6));
    push_exp(1, ref_mul(8'h9C, 8'h3B));
    #1;
    wait_gnt(5, g);
    n_checks++;
    if (g !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_first: got %b expected 01", g);
    end
    step();
    bus.Req = 2'b10;
    await_done(40, lat);
    n_checks++;
    if (lat + 1 != 18) begin
      n_fail++;
      $display("FAIL rr_latency: Done at cycle %0d, expected 18", lat + 1);
    end
    step();
    n_checks++;
    if (bus.Gnt !== 2'b10) begin
      n_fail++;
      $display("FAIL rr_second: got %b expected 10 at cycle 19", bus.Gnt);
    end
    step();
    bus.Req = 2'b00;
    await_done(40, lat);
    step();
  endtask

  task automatic test_reset_abort();
    logic [1:0] g;
    logic       saw_done = 1'b0;
    load_operands(0, 8'h5A, 8'hC3);
    bus.Req = 2'b01;
    #1;
    wait_gnt(40, g);
    step();
    bus.Req = 2'b00;
    repeat (8) step();
    n_checks++;
    if (bus.Shift !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_setup: shift=%b expected 1 in cycle 9", bus.Shift);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    #1;
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Product !== 16'h0000 || bus.ResultId !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b done=%b product=%h id=%b, expected 0 0 0000 0",
               bus.Busy, bus.Done, bus.Product, bus.ResultId);
    end
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.Done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: saw Done=%b after abort, expected 0", saw_done);
    end
    do_op(1, 8'h5A, 8'hC3, ref_mul(8'h5A, 8'hC3));
  endtask

  task automatic test_back_to_back();
    int         ids[5] = '{0, 0, 0, 1, 0};
    logic [7:0] mcs[5] = '{8'h11, 8'h7F, 8'h80, 8'h33, 8'hC0};
    logic [7:0] mps[5] = '{8'h0F, 8'h7F, 8'hFF, 8'hE5, 8'h40};
    logic [1:0] g;
    logic [1:0] nreq;
    logic [1:0] loaded;
    int         lat;
    int         t_prev = 0;
    load_operands(0, mcs[0], mps[0]);
    push_exp(0, ref_mul(mcs[0], mps[0]));
    bus.Req = 2'b01;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(25, g);
      n_checks++;
      if (g !== 2'(1 << ids[k])) begin
        n_fail++;
        $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, g, 2'(1 << ids[k]));
      end
      if (k > 0) begin
        n_checks++;
        if (cyc - t_prev != 19) begin
          n_fail++;
          $display("FAIL b2b_interval[%0d]: got %0d cycles expected 19", k, cyc - t_prev);
        end
      end
      t_prev = cyc;
      step();
      // Requester 0 stays asserted while it has work; requester 1 only when it is next.
      nreq   = 2'b00;
      loaded = 2'b00;
      if (k + 1 < 5) nreq[ids[k + 1]] = 1'b1;
      for (int j = k + 1; j < 5; j++) begin
        if (ids[j] == 0) nreq[0] = 1'b1;
        if (!loaded[ids[j]]) begin
          load_operands(ids[j], mcs[j], mps[j]);
          loaded[ids[j]] = 1'b1;
        end
      end
      bus.Req = nreq;
      if (k + 1 < 5) push_exp(ids[k + 1], ref_mul(mcs[k + 1], mps[k + 1]));
      await_done(25, lat);
      step();
    end
    bus.Req = 2'b00;
  endtask

  task automatic test_sweep();
    logic [7:0] corners[8] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h02, 8'hFE, 8'h81};
    logic [7:0] mc;
    logic [7:0] mp;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        do_op((i + j) % 2, corners[i], corners[j], ref_mul(corners[i], corners[j]));
      end
    end
    for (int n = 0; n < 40; n++) begin
      mc = 8'($urandom);
      mp = 8'($urandom);
      do_op(int'($urandom_range(0, 1)), mc, mp, ref_mul(mc, mp));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset       = 1'b1;
    bus.Req     = 2'b00;
    bus.Mcand0  = 8'h00;
    bus.Mcand1  = 8'h00;
    bus.Mplier0 = 8'h00;
    bus.Mplier1 = 8'h00;
    test_reset();
    test_basic();
    test_signed();
    test_round_robin();
    test_reset_abort();
    test_back_to_back();
    test_sweep();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
